// File: rtl/fir_cfg_sequencer_if.sv
// Configuration bus between fir_cfg_sequencer and its neighbours.
// Carries the coefficient-source fetch handshake and the FIR filter
// configuration ports (coefficient write, result shift, flush, read-back).
// master: the sequencer side. slave: the source/filter side.
interface fir_cfg_sequencer_if #(
    parameter int coef_width = 24,
    parameter int coef_count = 16,
    parameter int max_shift  = 32
) ();
    localparam int coef_id_w   = $clog2(coef_count);
    localparam int max_shift_w = $clog2(max_shift);

    // Coefficient source
    logic                   src_req;
    logic [coef_id_w-1:0]   src_addr;
    logic                   src_valid;
    logic [coef_width-1:0]  src_data;

    // FIR filter configuration ports
    logic [coef_id_w-1:0]   fir_addr;
    logic [coef_width-1:0]  fir_coef;
    logic                   fir_coef_ready;
    logic                   fir_coef_done;
    logic [coef_width-1:0]  fir_coef_r;
    logic                   fir_shift_ready;
    logic [max_shift_w-1:0] fir_shift;
    logic                   fir_shift_done;
    logic                   fir_flush;

    modport master (
        output src_req, src_addr,
        input  src_valid, src_data,
        output fir_addr, fir_coef, fir_coef_ready,
        input  fir_coef_done, fir_coef_r,
        output fir_shift_ready, fir_shift,
        input  fir_shift_done,
        output fir_flush
    );

    modport slave (
        input  src_req, src_addr,
        output src_valid, src_data,
        input  fir_addr, fir_coef, fir_coef_ready,
        output fir_coef_done, fir_coef_r,
        input  fir_shift_ready, fir_shift,
        output fir_shift_done,
        input  fir_flush
    );
endinterface

// File: rtl/fir_cfg_sequencer.sv
// fir_cfg_sequencer: loads coef_count coefficients from a source into the
// FIR filter, programs the result shift and flushes the filter.
// Optional read-back verify pass: define FIR_CFG_VERIFY_EN.
// All strobes and status outputs are registered; every handshake wait is
// bounded by timeout_cyc cycles, and abort cancels a sequence at any point.
module fir_cfg_sequencer #(
    parameter int  coef_width  = 24,
    parameter int  coef_count  = 16,
    parameter int  max_shift   = 32,
    parameter int  timeout_cyc = 255,
    localparam int coef_id_w   = $clog2(coef_count),
    localparam int max_shift_w = $clog2(max_shift)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [max_shift_w-1:0] shift_cfg,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [1:0]             err_code,
    output logic [coef_id_w-1:0]   err_idx,
    fir_cfg_sequencer_if.master    bus
);
    localparam int wait_w = $clog2(timeout_cyc + 1);

    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_ABORT   = 2'd3;
`ifdef FIR_CFG_VERIFY_EN
    localparam logic [1:0] ERR_VERIFY  = 2'd2;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WRITE,
        ST_SHIFT,
        ST_FLUSH,
        ST_DONE,
        ST_VFETCH,
        ST_VREAD
    } state_t;

    state_t                 state_reg;
    logic [coef_id_w-1:0]   index_reg;
    logic [wait_w-1:0]      wait_cnt_reg;
    logic                   busy_reg;
    logic                   done_reg;
    logic                   err_reg;
    logic [1:0]             err_code_reg;
    logic [coef_id_w-1:0]   err_idx_reg;
    logic                   src_req_reg;
    logic [coef_id_w-1:0]   src_addr_reg;
    logic [coef_id_w-1:0]   fir_addr_reg;
    logic [coef_width-1:0]  fir_coef_reg;
    logic                   coef_ready_reg;
    logic                   shift_ready_reg;
    logic [max_shift_w-1:0] fir_shift_reg;
    logic                   flush_reg;
`ifdef FIR_CFG_VERIFY_EN
    logic [coef_width-1:0]  verify_data_reg;
`else
    logic [coef_width-1:0]  unused_coef_r;
    assign unused_coef_r = bus.fir_coef_r;
`endif

    logic waiting;
    logic advance;
    logic timeout_hit;
    logic last_idx;

    assign timeout_hit = (wait_cnt_reg == wait_w'(timeout_cyc - 1));
    assign last_idx    = (index_reg == coef_id_w'(coef_count - 1));

    // Which states wait on a handshake, and whether that handshake completes
    // this cycle. coef_done only counts once coef_ready has been high for a
    // full cycle, so a late done from the previous write cannot be mistaken
    // for this one.
    always_comb begin
        waiting = 1'b0;
        advance = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                waiting = 1'b1;
                advance = bus.src_valid;
            end
            ST_WRITE: begin
                waiting = 1'b1;
                advance = bus.fir_coef_done && (wait_cnt_reg != '0);
            end
            ST_SHIFT: begin
                waiting = 1'b1;
                advance = bus.fir_shift_done;
            end
`ifdef FIR_CFG_VERIFY_EN
            ST_VFETCH: begin
                waiting = 1'b1;
                advance = bus.src_valid;
            end
`endif
            default: begin
                waiting = 1'b0;
                advance = 1'b0;
            end
        endcase
    end

    // Sequencer FSM with registered strobes; abort beats timeout beats progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            index_reg       <= '0;
            wait_cnt_reg    <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            err_reg         <= 1'b0;
            err_code_reg    <= '0;
            err_idx_reg     <= '0;
            src_req_reg     <= 1'b0;
            src_addr_reg    <= '0;
            fir_addr_reg    <= '0;
            fir_coef_reg    <= '0;
            coef_ready_reg  <= 1'b0;
            shift_ready_reg <= 1'b0;
            fir_shift_reg   <= '0;
            flush_reg       <= 1'b0;
`ifdef FIR_CFG_VERIFY_EN
            verify_data_reg <= '0;
`endif
        end else begin
            done_reg     <= 1'b0;
            flush_reg    <= 1'b0;
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
            if (state_reg != ST_IDLE && abort) begin
                state_reg       <= ST_IDLE;
                wait_cnt_reg    <= '0;
                busy_reg        <= 1'b0;
                src_req_reg     <= 1'b0;
                coef_ready_reg  <= 1'b0;
                shift_ready_reg <= 1'b0;
                err_reg         <= 1'b1;
                err_code_reg    <= ERR_ABORT;
                err_idx_reg     <= index_reg;
            end else if (waiting && !advance && timeout_hit) begin
                state_reg       <= ST_IDLE;
                wait_cnt_reg    <= '0;
                busy_reg        <= 1'b0;
                src_req_reg     <= 1'b0;
                coef_ready_reg  <= 1'b0;
                shift_ready_reg <= 1'b0;
                err_reg         <= 1'b1;
                err_code_reg    <= ERR_TIMEOUT;
                err_idx_reg     <= index_reg;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        wait_cnt_reg <= '0;
                        if (start) begin
                            state_reg     <= ST_FETCH;
                            index_reg     <= '0;
                            src_addr_reg  <= '0;
                            src_req_reg   <= 1'b1;
                            busy_reg      <= 1'b1;
                            err_reg       <= 1'b0;
                            err_code_reg  <= '0;
                            err_idx_reg   <= '0;
                            fir_shift_reg <= shift_cfg;
                        end
                    end
                    ST_FETCH: begin
                        if (advance) begin
                            state_reg      <= ST_WRITE;
                            wait_cnt_reg   <= '0;
                            src_req_reg    <= 1'b0;
                            fir_coef_reg   <= bus.src_data;
                            fir_addr_reg   <= index_reg;
                            coef_ready_reg <= 1'b1;
                        end
                    end
                    ST_WRITE: begin
                        if (advance) begin
                            wait_cnt_reg   <= '0;
                            coef_ready_reg <= 1'b0;
                            if (last_idx) begin
                                state_reg       <= ST_SHIFT;
                                shift_ready_reg <= 1'b1;
                            end else begin
                                state_reg    <= ST_FETCH;
                                index_reg    <= index_reg + 1'b1;
                                src_addr_reg <= index_reg + 1'b1;
                                src_req_reg  <= 1'b1;
                            end
                        end
                    end
                    ST_SHIFT: begin
                        if (advance) begin
                            state_reg       <= ST_FLUSH;
                            wait_cnt_reg    <= '0;
                            shift_ready_reg <= 1'b0;
                            flush_reg       <= 1'b1;
                        end
                    end
                    ST_FLUSH: begin
                        wait_cnt_reg <= '0;
`ifdef FIR_CFG_VERIFY_EN
                        state_reg    <= ST_VFETCH;
                        index_reg    <= '0;
                        src_addr_reg <= '0;
                        src_req_reg  <= 1'b1;
`else
                        state_reg    <= ST_DONE;
                        done_reg     <= 1'b1;
                        busy_reg     <= 1'b0;
`endif
                    end
`ifdef FIR_CFG_VERIFY_EN
                    ST_VFETCH: begin
                        if (advance) begin
                            state_reg       <= ST_VREAD;
                            wait_cnt_reg    <= '0;
                            src_req_reg     <= 1'b0;
                            verify_data_reg <= bus.src_data;
                            fir_addr_reg    <= index_reg;
                        end
                    end
                    ST_VREAD: begin
                        // coef_r is registered in the filter: compare on the second cycle
                        if (wait_cnt_reg == wait_w'(1)) begin
                            wait_cnt_reg <= '0;
                            if (bus.fir_coef_r != verify_data_reg) begin
                                state_reg    <= ST_IDLE;
                                busy_reg     <= 1'b0;
                                err_reg      <= 1'b1;
                                err_code_reg <= ERR_VERIFY;
                                err_idx_reg  <= index_reg;
                            end else if (last_idx) begin
                                state_reg <= ST_DONE;
                                done_reg  <= 1'b1;
                                busy_reg  <= 1'b0;
                            end else begin
                                state_reg    <= ST_VFETCH;
                                index_reg    <= index_reg + 1'b1;
                                src_addr_reg <= index_reg + 1'b1;
                                src_req_reg  <= 1'b1;
                            end
                        end
                    end
`endif
                    ST_DONE: begin
                        state_reg    <= ST_IDLE;
                        wait_cnt_reg <= '0;
                    end
                    default: begin
                        state_reg    <= ST_IDLE;
                        wait_cnt_reg <= '0;
                        busy_reg     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign err      = err_reg;
    assign err_code = err_code_reg;
    assign err_idx  = err_idx_reg;

    assign bus.src_req         = src_req_reg;
    assign bus.src_addr        = src_addr_reg;
    assign bus.fir_addr        = fir_addr_reg;
    assign bus.fir_coef        = fir_coef_reg;
    assign bus.fir_coef_ready  = coef_ready_reg;
    assign bus.fir_shift_ready = shift_ready_reg;
    assign bus.fir_shift       = fir_shift_reg;
    assign bus.fir_flush       = flush_reg;
endmodule

// File: tb/tb_fir_cfg_sequencer.sv
// Bench for fir_cfg_sequencer: coefficient source and FIR filter models,
// directed stimulus, and a scoreboard whose monitor checks every done pulse
// or error event against the expectation queued when the sequence started.
`timescale 1ns/1ps
module tb_fir_cfg_sequencer;
    localparam int N  = 16;
    localparam int CW = 24;
    localparam int IW = 4;
    localparam int SW = 5;
`ifdef FIR_CFG_VERIFY_EN
    localparam int VER_CYC  = 3 * N;
    localparam int REQ7_EXP = 7;
`else
    localparam int VER_CYC  = 0;
    localparam int REQ7_EXP = 6;
`endif
    localparam int NOMINAL = 3 * N + 4 + VER_CYC;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [SW-1:0] shift_cfg = '0;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;
    logic [IW-1:0] err_idx;

    fir_cfg_sequencer_if #(.coef_width(CW), .coef_count(N), .max_shift(32)) bus ();

    fir_cfg_sequencer #(
        .coef_width(CW), .coef_count(N), .max_shift(32), .timeout_cyc(255)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .shift_cfg(shift_cfg), .busy(busy), .done(done), .err(err),
        .err_code(err_code), .err_idx(err_idx), .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Source and filter models
    logic [CW-1:0] fmem [N];
    logic [SW-1:0] fshift = '0;
    int            flush_cnt = 0;
    logic          hang_en = 1'b0;
    logic          corrupt_en = 1'b0;
    logic          stall_en = 1'b0;
    int            stall_cnt = 0;
    logic          coef_done_q = 1'b0;
    logic          shift_done_q = 1'b0;
    logic [CW-1:0] coef_r_q = '0;

    assign bus.src_valid      = bus.src_req && !(stall_en && bus.src_addr == 4'd7 && stall_cnt < 5);
    assign bus.src_data       = 24'h100000 + CW'(bus.src_addr);
    assign bus.fir_coef_done  = coef_done_q;
    assign bus.fir_shift_done = shift_done_q;
    assign bus.fir_coef_r     = coef_r_q;

    always @(posedge clk) begin
        coef_done_q <= bus.fir_coef_ready && !(hang_en && bus.fir_addr == 4'd3);
        if (bus.fir_coef_ready) fmem[bus.fir_addr] <= bus.fir_coef;
        coef_r_q <= fmem[bus.fir_addr] ^ ((corrupt_en && bus.fir_addr == 4'd12) ? 24'h000001 : 24'h000000);
        shift_done_q <= bus.fir_shift_ready;
        if (bus.fir_shift_ready) fshift <= bus.fir_shift;
        if (bus.fir_flush) flush_cnt <= flush_cnt + 1;
        if (!stall_en) stall_cnt <= 0;
        else if (bus.src_req && bus.src_addr == 4'd7 && stall_cnt < 5) stall_cnt <= stall_cnt + 1;
    end

    // Scoreboard
    typedef struct {
        bit            is_done;
        logic [1:0]    code;
        logic [IW-1:0] idx;
        int            lat;
        int            t0;
        int            fl0;
        int            fl_exp;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail = 0;
    int t_start = 0;
    int fl_start = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input bit is_done, input logic [1:0] code, input logic [IW-1:0] idx,
                            input int lat, input int fl_exp);
        exp_t e;
        e.is_done = is_done; e.code = code; e.idx = idx; e.lat = lat;
        e.t0 = t_start; e.fl0 = fl_start; e.fl_exp = fl_exp;
        exp_q.push_back(e);
    endtask

    // Monitor: one transaction per done pulse or rising err
    logic err_q = 1'b0;
    int   req7 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            err_q = 1'b0;
        end else begin
            if (!stall_en) req7 = 0;
            else if (bus.src_req && bus.src_addr == 4'd7) req7 = req7 + 1;
            if (done || (err && !err_q)) begin
                $display("txn: done=%0b err=%0b code=%0d idx=%0d cycle=%0d", done, err, err_code, err_idx, cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {done, err, err_code}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", done, e.is_done);
                    check("err_flag", err, !e.is_done);
                    check("err_code", err_code, e.code);
                    if (!e.is_done) check("err_idx", err_idx, e.idx);
                    check("latency", cyc - e.t0 + 1, e.lat);
                    check("busy_low", busy, 0);
                    check("flush_count", flush_cnt - e.fl0, e.fl_exp);
                end
            end
            err_q = err;
        end
    end

    task automatic do_start(input logic [SW-1:0] sh, input logic with_abort);
        @(negedge clk);
        start = 1'b1; abort = with_abort; shift_cfg = sh;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        t_start = cyc; fl_start = flush_cnt;
        check("start_accepted_busy", busy, 1);
        check("start_clears_err", err, 0);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_status"}, {busy, done, err, err_code, err_idx}, 0);
        check({tag, "_strobes"}, {bus.src_req, bus.fir_coef_ready, bus.fir_shift_ready, bus.fir_flush}, 0);
        check({tag, "_addrs"}, {bus.src_addr, bus.fir_addr, bus.fir_shift}, 0);
        check({tag, "_coef"}, bus.fir_coef, 0);
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        // abort in IDLE is ignored
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        @(negedge clk);
        check("idle_abort_ignored", {err, busy}, 0);

        // Nominal run with an ignored start mid-sequence
        do_start(5'd10, 1'b0);
        push_exp(1'b1, 2'd0, '0, NOMINAL, 1);
        repeat (10) @(negedge clk);
        start = 1'b1; shift_cfg = 5'd7;
        @(negedge clk);
        start = 1'b0;
        drain(400);
        for (int i = 0; i < N; i++) check($sformatf("coef_mem_%0d", i), fmem[i], 24'h100000 + i);
        check("fir_shift_prog", fshift, 10);

        // Source stall on index 7; start and abort together in IDLE
        stall_en = 1'b1;
        do_start(5'd3, 1'b1);
        push_exp(1'b1, 2'd0, '0, NOMINAL + 5, 1);
        drain(400);
        check("stall_req_cycles_at_7", req7, REQ7_EXP);
        check("stall_shift", fshift, 3);
        stall_en = 1'b0;

        // Filter never acknowledges index 3
        hang_en = 1'b1;
        do_start(5'd10, 1'b0);
        push_exp(1'b0, 2'd1, 4'd3, 266, 0);
        drain(1000);
        hang_en = 1'b0;

        // Abort during WRITE of index 9, then restart
        do_start(5'd10, 1'b0);
        n = 0;
        while (!(bus.fir_coef_ready && bus.fir_addr == 4'd9) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_write_9", n < 200, 1);
        abort = 1'b1;
        push_exp(1'b0, 2'd3, 4'd9, cyc - t_start + 2, 0);
        @(negedge clk);
        abort = 1'b0;
        drain(50);
        do_start(5'd10, 1'b0);
        push_exp(1'b1, 2'd0, '0, NOMINAL, 1);
        drain(400);

        // Reset during SHIFT, then a full run
        do_start(5'd10, 1'b0);
        n = 0;
        while (!bus.fir_shift_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_shift", n < 200, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        do_start(5'd10, 1'b0);
        push_exp(1'b1, 2'd0, '0, NOMINAL, 1);
        drain(400);

`ifdef FIR_CFG_VERIFY_EN
        // Read-back mismatch on coefficient 12
        corrupt_en = 1'b1;
        do_start(5'd10, 1'b0);
        push_exp(1'b0, 2'd2, 4'd12, 91, 1);
        drain(400);
        corrupt_en = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
